// File: rtl/rx_phyretrain_responder.sv
// Receive-side PHYRETRAIN responder: waits for the partner's START_REQ, resolves the
// retrain encoding against the local one, sends START_RESP and reports completion.
module rx_phyretrain_responder #(
  parameter int unsigned SB_MSG_WIDTH   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 8000,
  parameter int unsigned CNT_WIDTH      = 13
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_phyretrain_en,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  input  logic                    i_rx_msg_valid,
  input  logic [2:0]              i_rx_msg_info,
  input  logic [2:0]              i_local_msg_info,
  input  logic                    i_falling_edge_busy,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx,
  output logic [2:0]              o_msg_info_rx,
  output logic                    o_valid_rx,
  output logic [2:0]              o_resolved_state,
  output logic                    o_phyretrain_end_rx,
  output logic                    o_timeout
);

  localparam logic [SB_MSG_WIDTH-1:0] MSG_START_REQ  = SB_MSG_WIDTH'(1);
  localparam logic [SB_MSG_WIDTH-1:0] MSG_START_RESP = SB_MSG_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0]    CNT_LAST       = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ENC_TXSELFCAL = 3'b001;
  localparam logic [2:0] ENC_SPEEDIDLE = 3'b010;
  localparam logic [2:0] ENC_REPAIR    = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_REQ,
    ST_SEND_RESP,
    ST_DONE,
    ST_TIMEOUT
  } state_e;

  state_e                  state_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [2:0]              partner_q;
  logic [SB_MSG_WIDTH-1:0] enc_msg_q;
  logic [2:0]              msg_info_q;
  logic                    valid_q;
  logic [2:0]              resolved_q;
  logic                    end_q;
  logic                    timeout_q;

  logic       latch_c;
  logic [2:0] partner_d;
  logic [2:0] resolved_c;

  // Partner value as it will be after this edge, resolved by priority SPEEDIDLE > REPAIR > TXSELFCAL
  always_comb begin
    latch_c    = i_phyretrain_en && (state_q == ST_WAIT_REQ) && i_rx_msg_valid &&
                 (i_decoded_SB_msg == MSG_START_REQ);
    partner_d  = latch_c ? i_rx_msg_info : partner_q;
    resolved_c = ENC_TXSELFCAL;
    if (partner_d[1] || i_local_msg_info[1]) begin
      resolved_c = ENC_SPEEDIDLE;
    end else if (partner_d[2] || i_local_msg_info[2]) begin
      resolved_c = ENC_REPAIR;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      partner_q  <= '0;
      enc_msg_q  <= '0;
      msg_info_q <= '0;
      valid_q    <= 1'b0;
      resolved_q <= '0;
      end_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else if (!i_phyretrain_en) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      enc_msg_q  <= '0;
      msg_info_q <= '0;
      valid_q    <= 1'b0;
      resolved_q <= '0;
      end_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT_REQ;
        end
        // A request on the final count still wins over the timeout
        ST_WAIT_REQ: begin
          if (latch_c) begin
            state_q    <= ST_SEND_RESP;
            partner_q  <= partner_d;
            enc_msg_q  <= MSG_START_RESP;
            msg_info_q <= resolved_c;
            resolved_q <= resolved_c;
            valid_q    <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= ST_TIMEOUT;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        // Busy pulses only count while our own response is pending
        ST_SEND_RESP: begin
          if (i_falling_edge_busy && valid_q) begin
            valid_q <= 1'b0;
            end_q   <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          end_q <= 1'b1;
        end
        ST_TIMEOUT: begin
          timeout_q <= 1'b1;
          valid_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_encoded_SB_msg_rx = enc_msg_q;
  assign o_msg_info_rx       = msg_info_q;
  assign o_valid_rx          = valid_q;
  assign o_resolved_state    = resolved_q;
  assign o_phyretrain_end_rx = end_q;
  assign o_timeout           = timeout_q;

endmodule

// File: tb/tb_rx_phyretrain_responder.sv
// Directed and randomized bench for rx_phyretrain_responder against a priority-list
// model of encoding resolution and a cycle-count model of the timeout window.
module tb_rx_phyretrain_responder;

  localparam int unsigned SBW = 4;
  localparam int unsigned TO  = 16;
  localparam int unsigned CW  = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [SBW-1:0] dec_msg;
  logic           msg_valid;
  logic [2:0]     msg_info;
  logic [2:0]     local_info;
  logic           busy;
  logic [SBW-1:0] enc_msg;
  logic [2:0]     info_out;
  logic           valid_out;
  logic [2:0]     res_state;
  logic           end_out;
  logic           timeout;

  int n_cmp = 0;
  int n_err = 0;

  rx_phyretrain_responder #(
    .SB_MSG_WIDTH  (SBW),
    .TIMEOUT_CYCLES(TO),
    .CNT_WIDTH     (CW)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_phyretrain_en    (en),
    .i_decoded_SB_msg   (dec_msg),
    .i_rx_msg_valid     (msg_valid),
    .i_rx_msg_info      (msg_info),
    .i_local_msg_info   (local_info),
    .i_falling_edge_busy(busy),
    .o_encoded_SB_msg_rx(enc_msg),
    .o_msg_info_rx      (info_out),
    .o_valid_rx         (valid_out),
    .o_resolved_state   (res_state),
    .o_phyretrain_end_rx(end_out),
    .o_timeout          (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Highest-priority encoding present in either side wins; nothing present means TXSELFCAL
  function automatic logic [2:0] ref_resolve(input logic [2:0] p, input logic [2:0] l);
    logic [2:0] prio [2];
    prio[0] = 3'b010;
    prio[1] = 3'b100;
    for (int i = 0; i < 2; i++) begin
      if (((p | l) & prio[i]) != 3'b000) return prio[i];
    end
    return 3'b001;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [SBW-1:0] e,
                         input logic [2:0] inf, input logic [2:0] r, input logic d,
                         input logic t);
    chk({tag, ".valid"},    32'(valid_out), 32'(v));
    chk({tag, ".enc"},      32'(enc_msg),   32'(e));
    chk({tag, ".info"},     32'(info_out),  32'(inf));
    chk({tag, ".resolved"}, 32'(res_state), 32'(r));
    chk({tag, ".end"},      32'(end_out),   32'(d));
    chk({tag, ".timeout"},  32'(timeout),   32'(t));
  endtask

  task automatic clear_msg();
    msg_valid = 1'b0;
    dec_msg   = '0;
    msg_info  = '0;
    busy      = 1'b0;
  endtask

  task automatic send_req(input logic [2:0] p);
    msg_valid = 1'b1;
    dec_msg   = SBW'(1);
    msg_info  = p;
  endtask

  // Full handshake from IDLE: optional noise in WAIT_REQ, duplicates in SEND_RESP, then disable
  task automatic run_hs(input string tag, input logic [2:0] p, input logic [2:0] l,
                        input int pre, input int bdly);
    logic [2:0] exp;
    exp        = ref_resolve(p, l);
    local_info = l;
    en         = 1'b1;
    step();
    for (int i = 0; i < pre; i++) begin
      busy      = 1'($urandom_range(0, 1));
      msg_valid = 1'b1;
      dec_msg   = SBW'(2);
      msg_info  = 3'($urandom_range(0, 7));
      step();
      clear_msg();
      chk({tag, ".wait_valid"}, 32'(valid_out), 32'(0));
    end
    send_req(p);
    step();
    clear_msg();
    chk_out({tag, ".resp"}, 1'b1, SBW'(2), exp, exp, 1'b0, 1'b0);
    for (int i = 0; i < bdly; i++) begin
      send_req(~p);
      local_info = 3'($urandom_range(0, 7));
      step();
      clear_msg();
      chk_out({tag, ".hold"}, 1'b1, SBW'(2), exp, exp, 1'b0, 1'b0);
    end
    busy = 1'b1;
    step();
    busy = 1'b0;
    chk_out({tag, ".done"}, 1'b0, SBW'(2), exp, exp, 1'b1, 1'b0);
    step();
    chk_out({tag, ".done_hold"}, 1'b0, SBW'(2), exp, exp, 1'b1, 1'b0);
    en = 1'b0;
    step();
    chk_out({tag, ".idle"}, 1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] pl_p [5];
    logic [2:0] pl_l [5];
    logic [2:0] exp;

    rst_n      = 1'b0;
    en         = 1'b0;
    local_info = '0;
    clear_msg();
    #2;
    chk_out("reset", 1'b0, '0, '0, '0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk_out("post_reset_idle", 1'b0, '0, '0, '0, 1'b0, 1'b0);

    run_hs("basic", 3'b001, 3'b001, 0, 2);

    pl_p[0] = 3'b001; pl_l[0] = 3'b100;
    pl_p[1] = 3'b100; pl_l[1] = 3'b010;
    pl_p[2] = 3'b010; pl_l[2] = 3'b001;
    pl_p[3] = 3'b000; pl_l[3] = 3'b000;
    pl_p[4] = 3'b110; pl_l[4] = 3'b001;
    for (int k = 0; k < 5; k++) begin
      run_hs($sformatf("sweep%0d", k), pl_p[k], pl_l[k], 1, 0);
    end

    // No request: timeout on the TO-th edge after entering WAIT_REQ, stray busy/other msgs ignored
    en = 1'b1;
    step();
    for (int i = 1; i <= int'(TO); i++) begin
      if (i == 5) busy = 1'b1;
      if (i == 7) begin
        msg_valid = 1'b1;
        dec_msg   = SBW'(2);
      end
      if (i == 9) begin
        msg_valid = 1'b0;
        dec_msg   = SBW'(1);
      end
      step();
      clear_msg();
      chk($sformatf("to_cnt%0d", i), 32'(timeout), 32'(i == int'(TO)));
      chk($sformatf("to_valid%0d", i), 32'(valid_out), 32'(0));
    end
    step();
    chk_out("to_held", 1'b0, '0, '0, '0, 1'b0, 1'b1);
    en = 1'b0;
    step();
    chk_out("to_cleared", 1'b0, '0, '0, '0, 1'b0, 1'b0);

    // Request on the final count wins over timeout
    en = 1'b1;
    step();
    for (int i = 1; i < int'(TO); i++) begin
      step();
      chk($sformatf("tie_cnt%0d", i), 32'(timeout), 32'(0));
    end
    local_info = 3'b001;
    send_req(3'b100);
    step();
    clear_msg();
    exp = ref_resolve(3'b100, 3'b001);
    chk_out("tie_resp", 1'b1, SBW'(2), exp, exp, 1'b0, 1'b0);
    send_req(3'b010);
    local_info = 3'b010;
    step();
    clear_msg();
    chk_out("dup_ignored", 1'b1, SBW'(2), exp, exp, 1'b0, 1'b0);
    step();
    step();
    chk_out("send_no_to", 1'b1, SBW'(2), exp, exp, 1'b0, 1'b0);
    en = 1'b0;
    step();
    chk_out("drop_in_send", 1'b0, '0, '0, '0, 1'b0, 1'b0);

    // Re-enable: the timeout window restarts from zero
    en = 1'b1;
    step();
    for (int i = 1; i <= int'(TO); i++) begin
      step();
      chk($sformatf("fresh_cnt%0d", i), 32'(timeout), 32'(i == int'(TO)));
    end
    en = 1'b0;
    step();

    // Asynchronous reset while in DONE
    local_info = 3'b100;
    en = 1'b1;
    step();
    send_req(3'b001);
    step();
    clear_msg();
    busy = 1'b1;
    step();
    busy = 1'b0;
    exp = ref_resolve(3'b001, 3'b100);
    chk_out("pre_rst_done", 1'b0, SBW'(2), exp, exp, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, '0, '0, '0, 1'b0, 1'b0);
    step();
    chk_out("rst_held", 1'b0, '0, '0, '0, 1'b0, 1'b0);
    en    = 1'b0;
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 12; k++) begin
      run_hs($sformatf("rand%0d", k), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             $urandom_range(0, 5), $urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
